ascii_frame_sender: RTL

//  Serialises a fixed-width packed ASCII digit string (char 0 = units digit in bits [7:0]) into a

---
 rtl/fuel_disp_pkg.sv | 17 +
 rtl/lz_blank.sv | 28 ++
 rtl/ascii_frame_sender.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fuel_disp_pkg.sv
// Shared state encoding and ASCII constants for the fuel display byte path.
package fuel_disp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIGITS = 3'd1,
        CR     = 3'd2,
        LF     = 3'd3,
        FIN    = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/lz_blank.sv
// Leading-zero blanking of a packed ASCII string; only built when LEADING_ZERO_BLANK_EN is defined.
`ifdef LEADING_ZERO_BLANK_EN
module lz_blank
    import fuel_disp_pkg::*;
#(
    parameter int NUM_CHARS = 6
) (
    input  logic [8*NUM_CHARS-1:0] str_i,
    output logic [8*NUM_CHARS-1:0] str_o
);

    logic leading;

    // Walk from the most-significant char down; char 0 is never blanked.
    always_comb begin
        str_o   = str_i;
        leading = 1'b1;
        for (int i = NUM_CHARS - 1; i >= 1; i--) begin
            if (leading && (str_i[8*i +: 8] == ASCII_ZERO)) begin
                str_o[8*i +: 8] = ASCII_SPACE;
            end else begin
                leading = 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/ascii_frame_sender.sv
// Serialises a packed ASCII digit string MSD-first over a valid/ready byte stream, optional CR LF.
// Optional leading-zero blanking at capture is enabled by defining LEADING_ZERO_BLANK_EN.
module ascii_frame_sender
    import fuel_disp_pkg::*;
#(
    parameter int NUM_CHARS   = 6,
    parameter int APPEND_CRLF = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*NUM_CHARS-1:0] ascii_str,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state_dbg_o
);

    localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    // Handshake: a byte moves on any cycle with tx_valid && tx_ready; tx_data/tx_valid
    // hold until that happens and tx_valid only drops without a transfer on reset.

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [8*NUM_CHARS-1:0] frame_q, frame_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [8*NUM_CHARS-1:0] cap_str;
    logic [IDX_W-1:0]       index_m1;
    logic                   xfer;

`ifdef LEADING_ZERO_BLANK_EN
    lz_blank #(.NUM_CHARS(NUM_CHARS)) u_lz_blank (
        .str_i (ascii_str),
        .str_o (cap_str)
    );
`else
    assign cap_str = ascii_str;
`endif

    function automatic logic [7:0] char_at(input logic [8*NUM_CHARS-1:0] s,
                                           input logic [IDX_W-1:0] k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (int'(k) == i) r = s[8*i +: 8];
        end
        return r;
    endfunction

    assign xfer     = tx_valid_q && tx_ready;
    assign index_m1 = index_q - IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        frame_d    = frame_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d    = cap_str;
                    index_d    = IDX_W'(NUM_CHARS - 1);
                    tx_data_d  = cap_str[8*(NUM_CHARS-1) +: 8];
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = DIGITS;
                end
            end
            DIGITS: begin
                if (xfer) begin
                    if (index_q != '0) begin
                        index_d   = index_m1;
                        tx_data_d = char_at(frame_q, index_m1);
                    end else if (APPEND_CRLF != 0) begin
                        state_d   = CR;
                        tx_data_d = ASCII_CR;
                    end else begin
                        state_d    = FIN;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            CR: begin
                if (xfer) begin
                    state_d   = LF;
                    tx_data_d = ASCII_LF;
                end
            end
            LF: begin
                if (xfer) begin
                    state_d    = FIN;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            FIN: begin
                // start is deliberately not looked at here; it is accepted from IDLE only.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            frame_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            frame_q    <= frame_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg_o = state_q;

endmodule
